// File: rtl/zion_clr_rr_arbiter_pkg.sv
// Shared types and helpers for the zion clear-capable round-robin arbiters.
package zion_clr_rr_arbiter_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zion_clr_dff.sv
// Register with async active-low reset and a synchronous clear, both to INI.
// One cycle latency; en gates the load, clr has priority over en.
module zion_clr_dff #(
  parameter int             W   = 1,
  parameter logic [W-1:0]   INI = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] dat_q;
  logic [W-1:0] dat_d;

  always_comb begin
    dat_d = dat_q;
    if (clr)     dat_d = INI;
    else if (en) dat_d = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dat_q <= INI;
    else      dat_q <= dat_d;
  end

  assign q = dat_q;

endmodule

// File: rtl/zion_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; no flow control of its own.
module zion_rr_pick
  import zion_clr_rr_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [idx_w(N)-1:0]    ptr,
  output logic [N-1:0]           pick,
  output logic [idx_w(N)-1:0]    idx,
  output logic                   any
);

  localparam int IW = idx_w(N);

  // Two passes: the upper segment [ptr, N) wins over the wrapped segment [0, ptr).
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && (j >= int'(ptr))) begin
        any     = 1'b1;
        idx     = IW'(j);
        pick[j] = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && req[j]) begin
        any     = 1'b1;
        idx     = IW'(j);
        pick[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zion_clr_rr_arbiter.sv
// Round-robin arbiter with burst lock feeding one clearable output register.
// 1-cycle grant-to-output latency; loads only when the register is empty or draining.
module zion_clr_rr_arbiter
  import zion_clr_rr_arbiter_pkg::*;
#(
  parameter int                 NUM_REQ  = 4,
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   INI_DATA = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             iClr,
  input  logic [NUM_REQ-1:0]               iReq,
  input  logic [NUM_REQ-1:0]               iLast,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    iDat,
  output logic [NUM_REQ-1:0]               oGnt,
  output logic                             oVld,
  output logic [WIDTH-1:0]                 oDat,
  input  logic                             iRdy,
  output logic [idx_w(NUM_REQ)-1:0]        oOwner,
  output logic                             oLocked
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      lock_own_q, lock_own_d;
  logic               locked_q, locked_d;

  logic               ld, fire, pick_any, last_beat;
  logic [NUM_REQ-1:0] pick_req, pick_oh;
  logic [IW-1:0]      pick_idx, idx_nxt;
  logic               vld_q;
  logic [IW-1:0]      owner_q;
  logic [IW:0]        vo_q;

  // Reset also gates ld so nothing is granted while the register is held in reset.
  assign ld = rst && !iClr && (!vld_q || iRdy);

  always_comb begin
    pick_req = iReq;
    if (state_q == LOCK) pick_req = iReq & (NUM_REQ'(1) << lock_own_q);
  end

  zion_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (pick_req),
    .ptr  (ptr_q),
    .pick (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign fire      = ld && pick_any;
  assign oGnt      = fire ? pick_oh : '0;
  assign last_beat = iLast[pick_idx];
  assign idx_nxt   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_own_d = lock_own_q;
    if (iClr) begin
      state_d    = ARB;
      ptr_d      = '0;
      lock_own_d = '0;
    end else if (fire) begin
      if (!last_beat) begin
        state_d    = LOCK;
        lock_own_d = pick_idx;
      end else begin
        state_d = ARB;
        ptr_d   = idx_nxt;
      end
    end
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      lock_own_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_own_q <= lock_own_d;
      locked_q   <= locked_d;
    end
  end

  zion_clr_dff #(.W(WIDTH), .INI(INI_DATA)) u_dat (
    .clk (clk),
    .rst (rst),
    .clr (iClr),
    .en  (fire),
    .d   (iDat[pick_idx]),
    .q   (oDat)
  );

  // A load with no grant empties the register but keeps the last owner.
  zion_clr_dff #(.W(IW + 1), .INI({(IW + 1){1'b0}})) u_vo (
    .clk (clk),
    .rst (rst),
    .clr (iClr),
    .en  (ld),
    .d   ({fire, fire ? pick_idx : owner_q}),
    .q   (vo_q)
  );

  assign vld_q   = vo_q[IW];
  assign owner_q = vo_q[IW-1:0];
  assign oVld    = vld_q;
  assign oOwner  = owner_q;
  assign oLocked = locked_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(oGnt));
  a_lock_excl  : assert property (@(posedge clk) disable iff (!rst)
    (state_q == LOCK) |-> ((oGnt & ~(NUM_REQ'(1) << lock_own_q)) == '0));
  a_lock_hold  : assert property (@(posedge clk) disable iff (!rst)
    ((state_q == LOCK) && !iReq[lock_own_q] && !iClr) |=> (state_q == LOCK));

endmodule

// File: tb/tb_zion_clr_rr_arbiter.sv
// Randomized and directed bench for zion_clr_rr_arbiter with a queue scoreboard.
module tb_zion_clr_rr_arbiter;

  localparam int             N   = 4;
  localparam int             W   = 32;
  localparam int             IW  = 2;
  localparam logic [W-1:0]   INI = 32'hDEAD_BEEF;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   iClr = 1'b0;
  logic                   iRdy = 1'b0;
  logic [N-1:0]           iReq = '0;
  logic [N-1:0]           iLast = '0;
  logic [N-1:0][W-1:0]    iDat = '0;
  logic [N-1:0]           oGnt;
  logic                   oVld;
  logic [W-1:0]           oDat;
  logic [IW-1:0]          oOwner;
  logic                   oLocked;

  zion_clr_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .INI_DATA(INI)) dut (
    .clk     (clk),
    .rst     (rst),
    .iClr    (iClr),
    .iReq    (iReq),
    .iLast   (iLast),
    .iDat    (iDat),
    .oGnt    (oGnt),
    .oVld    (oVld),
    .oDat    (oDat),
    .iRdy    (iRdy),
    .oOwner  (oOwner),
    .oLocked (oLocked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic         vld;
    logic [W-1:0] dat;
    int           own;
    logic         locked;
  } cyc_t;

  typedef struct {
    logic [W-1:0] dat;
    int           own;
  } beat_t;

  cyc_t  cq[$];
  beat_t bq[$];
  int    checks = 0;
  int    errors = 0;

  // Reference state: what the output register and arbiter hold right now.
  bit           m_vld;
  bit           m_locked;
  logic [W-1:0] m_dat;
  int           m_own, m_ptr, m_lown;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit has(input logic [N-1:0] v, input int i);
    return v[IW'(i)];
  endfunction

  task automatic model_reset();
    m_vld = 0; m_locked = 0; m_dat = INI; m_own = 0; m_ptr = 0; m_lown = 0;
  endtask

  task automatic step(input bit r, input logic [N-1:0] req, input logic [N-1:0] last,
                      input bit rdy, input bit clr);
    int   g;
    bit   ld;
    cyc_t c;
    @(posedge clk);
    #1;
    rst = r; iReq = req; iLast = last; iRdy = rdy; iClr = clr;
    iDat = {$urandom, $urandom, $urandom, $urandom};
    if (!r) begin
      model_reset();
      bq.delete();
    end
    ld = r && !clr && (!m_vld || rdy);
    g  = -1;
    if (ld) begin
      if (m_locked) begin
        if (has(req, m_lown)) g = m_lown;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && has(req, (m_ptr + k) % N)) g = (m_ptr + k) % N;
      end
    end
    c.gnt    = (g >= 0) ? (N'(1) << g) : '0;
    c.vld    = m_vld;
    c.dat    = m_dat;
    c.own    = m_own;
    c.locked = m_locked;
    cq.push_back(c);
    if (g >= 0) bq.push_back('{iDat[IW'(g)], g});
    // A held beat that is not drained in the clear cycle is lost.
    if (r && clr && m_vld && !rdy) bq.delete();
    if (r) begin
      if (clr) begin
        model_reset();
      end else if (ld) begin
        if (g >= 0) begin
          m_vld = 1; m_dat = iDat[IW'(g)]; m_own = g;
          if (!has(last, g)) begin
            m_locked = 1; m_lown = g;
          end else begin
            m_locked = 0; m_ptr = (g + 1) % N;
          end
        end else begin
          m_vld = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cyc_t  c;
    beat_t b;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      check("gnt",    64'(oGnt),    64'(c.gnt));
      check("vld",    64'(oVld),    64'(c.vld));
      check("dat",    64'(oDat),    64'(c.dat));
      check("owner",  64'(oOwner),  64'(c.own));
      check("locked", 64'(oLocked), 64'(c.locked));
      if (oVld && iRdy) begin
        if (bq.size() == 0) begin
          check("beat_expected", 64'd0, 64'd1);
        end else begin
          b = bq.pop_front();
          check("beat_dat",   64'(oDat),   64'(b.dat));
          check("beat_owner", 64'(oOwner), 64'(b.own));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) step(0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    repeat (3) step(1, 4'b0110, 4'b1111, 1, 0);

    step(1, 4'b0000, 4'b0000, 1, 1);
    step(1, 4'b1111, 4'b1111, 1, 0);
    repeat (3) step(1, 4'b1111, 4'b1111, 0, 0);
    repeat (5) step(1, 4'b1111, 4'b1111, 1, 0);

    step(1, 4'b0000, 4'b0000, 1, 1);
    step(1, 4'b0100, 4'b0000, 1, 0);
    step(1, 4'b0101, 4'b0000, 1, 0);
    step(1, 4'b0001, 4'b0000, 1, 0);
    step(1, 4'b0101, 4'b0100, 1, 0);
    step(1, 4'b0001, 4'b0001, 1, 0);
    step(1, 4'b0000, 4'b0000, 1, 0);

    step(1, 4'b0010, 4'b0000, 1, 0);
    step(1, 4'b0010, 4'b0000, 1, 1);
    step(1, 4'b0011, 4'b0000, 1, 0);
    step(1, 4'b0001, 4'b0001, 1, 0);

    step(1, 4'b1000, 4'b1111, 1, 0);
    step(1, 4'b1001, 4'b1111, 1, 0);
    step(1, 4'b1001, 4'b1111, 1, 0);

    step(1, 4'b0001, 4'b0001, 1, 0);
    step(1, 4'b0000, 4'b0000, 1, 1);
    step(1, 4'b0000, 4'b0000, 1, 0);
    step(1, 4'b0100, 4'b0100, 1, 0);
    step(1, 4'b0000, 4'b0000, 0, 1);
    step(1, 4'b0000, 4'b0000, 1, 0);

    for (int i = 0; i < 500; i++)
      step(1, 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 40) == 0));

    step(1, 4'b0000, 4'b0000, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    if (cq.size() != 0) check("drain", 64'(cq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
